// File: rtl/l1_fill_arbiter.sv
// l1_fill_arbiter: shares one L1-to-memory request/return port between NUM_REQ
// requesters. Grants one transaction at a time with round-robin fairness,
// drives the memory request handshake and routes returned burst words to the
// owning requester with a last-word marker.
// Optional feature: define L1_FILL_ARB_ERR_EN to add a sticky protocol_error
// output that flags return data outside FILL or mem_ack outside REQUEST.

module l1_fill_arbiter #(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned SIZE_W  = 5
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [NUM_REQ-1:0][31:0]       req_addr,
   input  logic [NUM_REQ-1:0]             req_rnw,
   input  logic [NUM_REQ-1:0][SIZE_W-1:0] req_size,
   input  logic [NUM_REQ-1:0][31:0]       req_wdata,
   output logic [NUM_REQ-1:0]             req_ack,
   output logic                           mem_request,
   output logic [31:0]                    mem_addr,
   output logic                           mem_rnw,
   output logic [SIZE_W-1:0]              mem_size,
   output logic [31:0]                    mem_wdata,
   input  logic                           mem_ack,
   input  logic                           mem_data_valid,
   input  logic [31:0]                    mem_data,
   output logic [NUM_REQ-1:0]             rsp_data_valid,
   output logic [NUM_REQ-1:0]             rsp_last,
   output logic [31:0]                    rsp_data,
   output logic                           busy
`ifdef L1_FILL_ARB_ERR_EN
   ,
   output logic                           protocol_error
`endif
);

   localparam int unsigned OwnW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {StIdle, StRequest, StFill} state_e;

   state_e            state_q;
   logic [OwnW-1:0]   owner_q;
   logic [OwnW-1:0]   rr_ptr_q;
   logic [SIZE_W-1:0] word_count_q;

   logic [OwnW-1:0]   pick_idx;
   logic              pick_found;
   logic [OwnW-1:0]   owner_inc;
   logic              ack_fire;
   logic              word_fire;
   logic              last_word;

   assign ack_fire    = (state_q == StRequest) && mem_ack;
   assign word_fire   = (state_q == StFill) && mem_data_valid;
   assign last_word   = (word_count_q == mem_size);
   assign owner_inc   = (owner_q == OwnW'(NUM_REQ - 1)) ? '0 : owner_q + OwnW'(1);
   assign mem_request = (state_q == StRequest);
   assign busy        = (state_q != StIdle);
   // Gated so the shared data bus reads zero whenever no burst is in flight.
   assign rsp_data    = (state_q == StFill) ? mem_data : '0;

   // Round-robin pick: first pending requester at or above rr_ptr, wrapping.
   always_comb begin
      int unsigned     idx;
      logic [OwnW-1:0] cand;
      pick_found = 1'b0;
      pick_idx   = '0;
      idx        = 0;
      cand       = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         idx  = (32'(rr_ptr_q) + k) % NUM_REQ;
         cand = OwnW'(idx);
         if (!pick_found && req_valid[cand]) begin
            pick_found = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   // Steer ack and return-word strobes to the current owner only.
   always_comb begin
      req_ack        = '0;
      rsp_data_valid = '0;
      rsp_last       = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (owner_q == OwnW'(i)) begin
            req_ack[i]        = ack_fire;
            rsp_data_valid[i] = word_fire;
            rsp_last[i]       = word_fire && last_word;
         end
      end
   end

   // Transaction FSM with latched request fields and burst word counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= StIdle;
         owner_q      <= '0;
         rr_ptr_q     <= '0;
         word_count_q <= '0;
         mem_addr     <= '0;
         mem_rnw      <= 1'b0;
         mem_size     <= '0;
         mem_wdata    <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (pick_found) begin
                  owner_q   <= pick_idx;
                  mem_addr  <= req_addr[pick_idx];
                  mem_rnw   <= req_rnw[pick_idx];
                  mem_size  <= req_size[pick_idx];
                  mem_wdata <= req_wdata[pick_idx];
                  state_q   <= StRequest;
               end
            end
            StRequest: begin
               // Return data arriving alongside the ack is dropped here.
               if (mem_ack) begin
                  rr_ptr_q <= owner_inc;
                  if (mem_rnw) begin
                     word_count_q <= '0;
                     state_q      <= StFill;
                  end else begin
                     state_q <= StIdle;
                  end
               end
            end
            StFill: begin
               if (mem_data_valid) begin
                  // Compare before increment so size 2^SIZE_W-1 never wraps.
                  if (last_word) begin
                     word_count_q <= '0;
                     state_q      <= StIdle;
                  end else begin
                     word_count_q <= word_count_q + SIZE_W'(1);
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

`ifdef L1_FILL_ARB_ERR_EN
   // Sticky flag for handshake events that arrive in the wrong state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         protocol_error <= 1'b0;
      end else if ((mem_data_valid && state_q != StFill) ||
                   (mem_ack && state_q != StRequest)) begin
         protocol_error <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_l1_fill_arbiter.sv
// tb_l1_fill_arbiter: directed bench for l1_fill_arbiter with hand-computed
// expectations (grant order, handshake timing, burst routing, reset).

module tb_l1_fill_arbiter;

   localparam int unsigned NUM_REQ = 2;
   localparam int unsigned SIZE_W  = 5;

   logic                           clk = 1'b0;
   logic                           rst;
   logic [NUM_REQ-1:0]             req_valid;
   logic [NUM_REQ-1:0][31:0]       req_addr;
   logic [NUM_REQ-1:0]             req_rnw;
   logic [NUM_REQ-1:0][SIZE_W-1:0] req_size;
   logic [NUM_REQ-1:0][31:0]       req_wdata;
   logic [NUM_REQ-1:0]             req_ack;
   logic                           mem_request;
   logic [31:0]                    mem_addr;
   logic                           mem_rnw;
   logic [SIZE_W-1:0]              mem_size;
   logic [31:0]                    mem_wdata;
   logic                           mem_ack;
   logic                           mem_data_valid;
   logic [31:0]                    mem_data;
   logic [NUM_REQ-1:0]             rsp_data_valid;
   logic [NUM_REQ-1:0]             rsp_last;
   logic [31:0]                    rsp_data;
   logic                           busy;
`ifdef L1_FILL_ARB_ERR_EN
   logic                           protocol_error;
`endif

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   l1_fill_arbiter #(
      .NUM_REQ (NUM_REQ),
      .SIZE_W  (SIZE_W)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid      (req_valid),
      .req_addr       (req_addr),
      .req_rnw        (req_rnw),
      .req_size       (req_size),
      .req_wdata      (req_wdata),
      .req_ack        (req_ack),
      .mem_request    (mem_request),
      .mem_addr       (mem_addr),
      .mem_rnw        (mem_rnw),
      .mem_size       (mem_size),
      .mem_wdata      (mem_wdata),
      .mem_ack        (mem_ack),
      .mem_data_valid (mem_data_valid),
      .mem_data       (mem_data),
      .rsp_data_valid (rsp_data_valid),
      .rsp_last       (rsp_last),
      .rsp_data       (rsp_data),
      .busy           (busy)
`ifdef L1_FILL_ARB_ERR_EN
      ,
      .protocol_error (protocol_error)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required $finish before 200000");
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h required 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Starts with the DUT in IDLE and request inputs set; ends at the falling
   // edge of the first IDLE cycle after the transaction (or right after an
   // asynchronous reset when abort_at matches a word index).
   task automatic run_txn(input int own, input logic [31:0] addr, input bit rnw,
                          input int size, input logic [31:0] wdata,
                          input int ack_wait, input int abort_at);
      logic [31:0] oh;
      oh = 32'd1 << own;
      step();
      @(negedge clk);
      check_eq("grant_request", mem_request, 1);
      check_eq("grant_addr", mem_addr, addr);
      check_eq("grant_rnw", mem_rnw, rnw);
      if (rnw) check_eq("grant_size", mem_size, size);
      else     check_eq("grant_wdata", mem_wdata, wdata);
      check_eq("grant_no_ack", req_ack, 0);
      for (int i = 0; i < ack_wait; i++) begin
         step();
         @(negedge clk);
         check_eq("request_held", mem_request, 1);
         check_eq("request_no_ack", req_ack, 0);
      end
      mem_ack        = 1'b1;
      mem_data_valid = 1'b1;
      mem_data       = 32'hBAD0_0000;
      #1;
      check_eq("ack_pulse", req_ack, oh);
      check_eq("ack_cycle_data_dropped", rsp_data_valid, 0);
      step();
      mem_ack        = 1'b0;
      mem_data_valid = 1'b0;
      @(negedge clk);
      check_eq("request_dropped", mem_request, 0);
      check_eq("ack_one_cycle", req_ack, 0);
      if (rnw) begin
         check_eq("fill_busy", busy, 1);
         for (int k = 0; k <= size; k++) begin
            if (k == abort_at) begin
               mem_data_valid = 1'b1;
               mem_data       = 32'h5555_0000;
               rst            = 1'b0;
               #1;
               check_eq("abort_busy", busy, 0);
               check_eq("abort_request", mem_request, 0);
               check_eq("abort_rsp_valid", rsp_data_valid, 0);
               check_eq("abort_rsp_last", rsp_last, 0);
               check_eq("abort_rsp_data", rsp_data, 0);
               check_eq("abort_mem_addr", mem_addr, 0);
               check_eq("abort_req_ack", req_ack, 0);
               return;
            end
            mem_data_valid = 1'b1;
            mem_data       = addr + 32'(k);
            #1;
            check_eq("word_valid", rsp_data_valid, oh);
            check_eq("word_last", rsp_last, (k == size) ? oh : 32'd0);
            check_eq("word_data", rsp_data, addr + 32'(k));
            step();
            mem_data_valid = 1'b0;
            @(negedge clk);
         end
      end
      check_eq("end_idle", busy, 0);
      check_eq("end_no_rsp", rsp_data_valid, 0);
   endtask

   initial begin
      rst            = 1'b0;
      req_valid      = '0;
      req_addr       = '0;
      req_rnw        = '0;
      req_size       = '0;
      req_wdata      = '0;
      mem_ack        = 1'b0;
      mem_data_valid = 1'b0;
      mem_data       = '0;

      #12;
      check_eq("reset_busy", busy, 0);
      check_eq("reset_request", mem_request, 0);
      check_eq("reset_req_ack", req_ack, 0);
      check_eq("reset_rsp_valid", rsp_data_valid, 0);
      check_eq("reset_mem_addr", mem_addr, 0);
      check_eq("reset_mem_wdata", mem_wdata, 0);
`ifdef L1_FILL_ARB_ERR_EN
      check_eq("reset_protocol_error", protocol_error, 0);
`endif
      @(negedge clk);
      rst = 1'b1;

      // Contention: both held valid, grants alternate 0,1,0,1 from reset.
      req_valid    = 2'b11;
      req_addr[0]  = 32'h0000_2000;
      req_rnw[0]   = 1'b1;
      req_size[0]  = 5'd1;
      req_addr[1]  = 32'h0000_3000;
      req_rnw[1]   = 1'b0;
      req_size[1]  = 5'd0;
      req_wdata[1] = 32'h1234_5678;
      run_txn(0, 32'h0000_2000, 1'b1, 1, 32'h0, 0, -1);
      run_txn(1, 32'h0000_3000, 1'b0, 0, 32'h1234_5678, 1, -1);
      run_txn(0, 32'h0000_2000, 1'b1, 1, 32'h0, 0, -1);
      run_txn(1, 32'h0000_3000, 1'b0, 0, 32'h1234_5678, 0, -1);
      req_valid = '0;

      // Single 8-word read, ack in the third REQUEST cycle.
      req_valid   = 2'b01;
      req_addr[0] = 32'h0000_1040;
      req_rnw[0]  = 1'b1;
      req_size[0] = 5'd7;
      run_txn(0, 32'h0000_1040, 1'b1, 7, 32'h0, 2, -1);
      req_valid = '0;
      step();
      @(negedge clk);
      check_eq("read_stays_idle", busy, 0);

      // Single write from requester 1.
      req_valid    = 2'b10;
      req_addr[1]  = 32'h8000_0000;
      req_rnw[1]   = 1'b0;
      req_wdata[1] = 32'hDEAD_BEEF;
      run_txn(1, 32'h8000_0000, 1'b0, 0, 32'hDEAD_BEEF, 1, -1);
      req_valid = '0;

      // Spurious return data and ack while IDLE.
      mem_data_valid = 1'b1;
      mem_ack        = 1'b1;
      mem_data       = 32'hFFFF_0001;
      #1;
      check_eq("spurious_rsp_valid", rsp_data_valid, 0);
      check_eq("spurious_req_ack", req_ack, 0);
      step();
      mem_data_valid = 1'b0;
      mem_ack        = 1'b0;
      @(negedge clk);
      check_eq("spurious_busy", busy, 0);
      check_eq("spurious_request", mem_request, 0);
`ifdef L1_FILL_ARB_ERR_EN
      check_eq("spurious_protocol_error", protocol_error, 1);
      step();
      @(negedge clk);
      check_eq("protocol_error_sticky", protocol_error, 1);
`endif

      // Reset after 3 of 8 words, then a single-word read completes.
      req_valid   = 2'b01;
      req_addr[0] = 32'h0000_4000;
      req_rnw[0]  = 1'b1;
      req_size[0] = 5'd7;
      run_txn(0, 32'h0000_4000, 1'b1, 7, 32'h0, 0, 3);
      req_valid      = '0;
      mem_data_valid = 1'b0;
      @(negedge clk);
      check_eq("in_reset_busy", busy, 0);
`ifdef L1_FILL_ARB_ERR_EN
      check_eq("reset_clears_protocol_error", protocol_error, 0);
`endif
      rst         = 1'b1;
      req_valid   = 2'b01;
      req_addr[0] = 32'h0000_5000;
      req_size[0] = 5'd0;
      run_txn(0, 32'h0000_5000, 1'b1, 0, 32'h0, 0, -1);
      req_valid = '0;

      // Maximum burst: 32 words, last only on the 32nd.
      req_valid   = 2'b10;
      req_addr[1] = 32'h0000_6000;
      req_rnw[1]  = 1'b1;
      req_size[1] = 5'd31;
      run_txn(1, 32'h0000_6000, 1'b1, 31, 32'h0, 0, -1);
      req_valid = '0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/l1_fill_arbiter.md
# l1_fill_arbiter

Shares a single L1-to-memory request/return port between NUM_REQ requesters (instruction cache, data cache, page-table walker). It grants one transaction at a time with round-robin fairness, drives the memory request handshake, counts returned burst words and routes them to the owning requester with a last-word marker. It sits between the L1 caches' request/response ports and the memory-side arbiter port.

## Interface
- NUM_REQ, 2, number of requesters (2..4)
- SIZE_W, 5, width of size field (burst words minus 1)

- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- req_valid  in  NUM_REQ  requester i has a pending transaction; held until req_ack[i]
- req_addr  in  NUM_REQ x 32  byte address per requester
- req_rnw  in  NUM_REQ  1 = read burst, 0 = single-word write
- req_size  in  NUM_REQ x SIZE_W  words-1 (reads); ignored for writes
- req_wdata  in  NUM_REQ x 32  write data
- req_ack  out  NUM_REQ  one-cycle pulse: transaction accepted by memory
- mem_request  out  1  request to memory port
- mem_addr  out  32  latched address of granted requester
- mem_rnw, mem_size, mem_wdata  out  1/SIZE_W/32  latched fields of granted requester
- mem_ack  in  1  memory accepts request
- mem_data_valid  in  1  return word valid
- mem_data  in  32  return word
- rsp_data_valid  out  NUM_REQ  return word belongs to requester i
- rsp_last  out  NUM_REQ  this is the final word of requester i's burst
- rsp_data  out  32  mem_data passed through, shared by all requesters
- busy  out  1  state != IDLE

## Operation
- States: IDLE, REQUEST, FILL.
- IDLE: if any req_valid, pick the first set bit searching upward from rr_ptr (wrapping); latch owner index, addr, rnw, size, wdata; go REQUEST.
- REQUEST: mem_request=1 with latched fields. On mem_ack: req_ack[owner]=1 same cycle; rr_ptr <= (owner+1) mod NUM_REQ; read -> FILL with word_count=0; write -> IDLE.
- FILL: each mem_data_valid: rsp_data_valid[owner]=1, word_count+1. rsp_last[owner]=1 when word_count==latched size; then go IDLE, word_count cleared.
- word_count is SIZE_W bits; size 0 means one word; size 2^SIZE_W-1 completes without wrap error.
- Only one transaction outstanding; requesters not granted keep req_valid asserted.
- mem_data_valid in IDLE or REQUEST is dropped (no rsp_data_valid).
- Requester dropping req_valid after grant does not abort; the latched transaction completes.

## Timing
- Reset (asynchronous assert, synchronous release): state IDLE, rr_ptr 0, word_count 0, owner 0, latched fields 0; all outputs 0.
- Grant latency: req_valid seen in IDLE at cycle N -> mem_request=1 at cycle N+1.
- req_ack is combinational from mem_ack in REQUEST; mem_request drops the cycle after ack.
- rsp_data_valid/rsp_last/rsp_data combinational from mem_data_valid/mem_data (zero latency).
- After write ack or last read word, state is IDLE next cycle; next grant at earliest one cycle later (minimum 2 idle-to-request gap cycles between back-to-back transactions: IDLE, then REQUEST).
- mem_ack and mem_data_valid in the same REQUEST cycle: ack honoured, data dropped.
- Simultaneous req_valid from all requesters: grant order strictly rotates from rr_ptr.

## Configuration
- L1_FILL_ARB_ERR_EN defined: adds output protocol_error (1 bit), sticky, set when mem_data_valid arrives outside FILL or mem_ack arrives outside REQUEST; cleared only by reset.
- Undefined: port absent; such events silently ignored.

## Test plan
- Single read: req 0 valid, addr 0x0000_1040, size 7; mem_ack cycle 3 -> mem_request cycles 1-3, req_ack[0] at cycle 3, 8 rsp_data_valid[0] pulses, rsp_last[0] on 8th only, busy low afterwards.
- Contention: req 0 and 1 valid together from reset -> req 0 granted first, then 1; repeat with both still valid -> 0 then 1 alternate (rr_ptr rotation).
- Write: req 1 rnw=0, addr 0x8000_0000, wdata 0xDEAD_BEEF -> mem_wdata=0xDEAD_BEEF, mem_rnw=0, IDLE cycle after ack, no rsp_data_valid.
- Spurious data: mem_data_valid=1 while IDLE -> no rsp_data_valid; with L1_FILL_ARB_ERR_EN, protocol_error=1 and stays 1.
- Reset mid-burst: rst low after 3 of 8 words -> all outputs 0 immediately, state IDLE; after release a new size-0 read completes with 1 word and rsp_last.
- Max size: size 31 -> 32 words, rsp_last only on 32nd, no wrap-induced early completion.
